shift_seq_reg: RTL and testbench



---
 rtl/shift_seq_reg_if.sv | 27 ++
 rtl/shift_seq_reg.sv | 103 ++++++++++
 tb/tb_shift_seq_reg.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_reg_if.sv
// Handshake and data bundle for shift_seq_reg: the load/start controls go in,
// and the register contents and sequencer status come out.
interface shift_seq_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic [2:0]       mode;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             busy;
  logic             done;

  modport master (
    output load_en, load_data, start, amount, mode, serial_in,
    input  q, serial_out, busy, done
  );

  modport slave (
    input  load_en, load_data, start, amount, mode, serial_in,
    output q, serial_out, busy, done
  );
endinterface

// File: rtl/shift_seq_reg.sv
// Universal shift register with a sequencer that runs an N-step shift one bit
// per cycle, reported through the busy/done handshake.
module shift_seq_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  shift_seq_reg_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] M_LSL  = 3'b000;
  localparam logic [2:0] M_LSR  = 3'b001;
  localparam logic [2:0] M_ROL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ASR  = 3'b100;
  localparam logic [2:0] M_SIL  = 3'b101;
  localparam logic [2:0] M_SIR  = 3'b110;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       mode_l;
  logic [WIDTH-1:0] q_r;
  logic             so_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH:0]   step_nxt;

  // Returns {bit shifted out, next q}; HOLD passes the previous serial_out through.
  function automatic logic [WIDTH:0] shift_step(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] d,
    input logic             si,
    input logic             so_prev
  );
    logic signed [WIDTH-1:0] ds;
    logic        [WIDTH-1:0] asr;
    ds  = d;
    asr = ds >>> 1;
    case (m)
      M_LSL:   return {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      M_LSR:   return {d[0], 1'b0, d[WIDTH-1:1]};
      M_ROL:   return {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      M_ROR:   return {d[0], d[0], d[WIDTH-1:1]};
      M_ASR:   return {d[0], asr};
      M_SIL:   return {d[WIDTH-1], d[WIDTH-2:0], si};
      M_SIR:   return {d[0], si, d[WIDTH-1:1]};
      default: return {so_prev, d};
    endcase
  endfunction

  always_comb begin
    step_nxt = shift_step(mode_l, q_r, bus.serial_in, so_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mode_l <= '0;
      q_r    <= '0;
      so_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load_en) begin
            q_r <= bus.load_data;
          end else if (bus.start) begin
            if (bus.amount == '0) begin
              done_r <= 1'b1;
            end else begin
              mode_l <= bus.mode;
              cnt    <= bus.amount;
              state  <= SHIFT;
              busy_r <= 1'b1;
            end
          end
        end
        SHIFT: begin
          {so_r, q_r} <= step_nxt;
          cnt         <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q          = q_r;
  assign bus.serial_out = so_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_shift_seq_reg.sv
// Bench for shift_seq_reg: vector table of load/shift operations scored through
// an expectation queue, plus hand-written handshake and reset sequences.
module tb_shift_seq_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  shift_seq_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  shift_seq_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       so;
    int         n;
  } exp_t;

  typedef struct {
    logic [7:0]  ld;
    logic [2:0]  mode;
    logic [3:0]  amt;
    logic [15:0] si;
    logic [7:0]  exp_q;
    logic        exp_so;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] d);
    bus.load_en   = 1'b1;
    bus.load_data = d;
    @(negedge clk);
    bus.load_en   = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] m, input logic [3:0] a,
                          input logic [7:0] eq, input logic es);
    exp_t e;
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.amount = a;
    e.q  = eq;
    e.so = es;
    e.n  = int'(a);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Drives serial_in per step, optionally disturbs controls mid-operation,
  // then pops the expected result when done is seen.
  task automatic wait_done(input string tag, input logic [15:0] si, input bit disturb);
    int   nb = 0;
    bit   seen = 1'b0;
    exp_t e;
    for (int c = 0; c < 64 && !seen; c++) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) begin
          nb++;
          bus.serial_in = si[nb-1];
          if (disturb && nb == 2) begin
            bus.load_en   = 1'b1;
            bus.load_data = 8'hFF;
            bus.start     = 1'b1;
            bus.mode      = 3'b000;
            bus.amount    = 4'd1;
          end else begin
            bus.load_en = 1'b0;
            bus.start   = 1'b0;
          end
        end
        @(negedge clk);
      end
    end
    bus.load_en = 1'b0;
    bus.start   = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard got empty queue want entry", tag);
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got no done want done", tag);
    end else begin
      check({tag, "_q"}, 16'(bus.q), 16'(e.q));
      check({tag, "_so"}, 16'(bus.serial_out), 16'(e.so));
      check({tag, "_busy_cycles"}, 16'(nb), 16'(e.n));
      check({tag, "_busy_at_done"}, 16'(bus.busy), 16'(0));
    end
  endtask

  initial begin
    vecs[0]  = '{8'hA5, 3'b010, 4'd3,  16'h0000, 8'h2D, 1'b1};
    vecs[1]  = '{8'h90, 3'b100, 4'd2,  16'h0000, 8'hE4, 1'b0};
    vecs[2]  = '{8'h00, 3'b101, 4'd4,  16'h000D, 8'h0B, 1'b0};
    vecs[3]  = '{8'hFF, 3'b000, 4'd9,  16'h0000, 8'h00, 1'b0};
    vecs[4]  = '{8'h3C, 3'b010, 4'd0,  16'h0000, 8'h3C, 1'b0};
    vecs[5]  = '{8'h81, 3'b001, 4'd1,  16'h0000, 8'h40, 1'b1};
    vecs[6]  = '{8'h5A, 3'b111, 4'd3,  16'h0000, 8'h5A, 1'b1};
    vecs[7]  = '{8'h00, 3'b110, 4'd3,  16'h0003, 8'h60, 1'b0};
    vecs[8]  = '{8'h80, 3'b100, 4'd12, 16'h0000, 8'hFF, 1'b1};
    vecs[9]  = '{8'h81, 3'b010, 4'd10, 16'h0000, 8'h06, 1'b0};
    vecs[10] = '{8'h01, 3'b011, 4'd9,  16'h0000, 8'h80, 1'b1};
    vecs[11] = '{8'h3C, 3'b011, 4'd0,  16'h0000, 8'h3C, 1'b1};

    bus.load_en   = 1'b0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.amount    = '0;
    bus.mode      = '0;
    bus.serial_in = 1'b0;

    #12;
    check("reset_q", 16'(bus.q), 16'(0));
    check("reset_so", 16'(bus.serial_out), 16'(0));
    check("reset_busy", 16'(bus.busy), 16'(0));
    check("reset_done", 16'(bus.done), 16'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_load(vecs[i].ld);
      start_op(vecs[i].mode, vecs[i].amt, vecs[i].exp_q, vecs[i].exp_so);
      wait_done($sformatf("vec%0d", i), vecs[i].si, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_done_clear", i), 16'(bus.done), 16'(0));
    end

    // load_en wins over start in IDLE
    bus.load_en   = 1'b1;
    bus.start     = 1'b1;
    bus.load_data = 8'h11;
    bus.mode      = 3'b010;
    bus.amount    = 4'd3;
    @(negedge clk);
    bus.load_en = 1'b0;
    bus.start   = 1'b0;
    check("ld_start_q", 16'(bus.q), 16'h11);
    check("ld_start_busy", 16'(bus.busy), 16'(0));
    @(negedge clk);
    check("ld_start_busy2", 16'(bus.busy), 16'(0));
    check("ld_start_done", 16'(bus.done), 16'(0));
    check("ld_start_q2", 16'(bus.q), 16'h11);

    // busy ROR ignores controls; a start in the done cycle is accepted
    do_load(8'h96);
    start_op(3'b011, 4'd4, 8'h69, 1'b0);
    wait_done("busy_ror", 16'h0000, 1'b1);
    start_op(3'b010, 4'd1, 8'hD2, 1'b0);
    check("done_cycle_start_busy", 16'(bus.busy), 16'(1));
    wait_done("done_cycle_start", 16'h0000, 1'b0);
    @(negedge clk);

    // asynchronous reset in the middle of a ROR amount=5
    do_load(8'hA5);
    bus.start  = 1'b1;
    bus.mode   = 3'b011;
    bus.amount = 4'd5;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("mid_op_q", 16'(bus.q), 16'hD2);
    check("mid_op_so", 16'(bus.serial_out), 16'(1));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_q", 16'(bus.q), 16'(0));
    check("async_rst_so", 16'(bus.serial_out), 16'(0));
    check("async_rst_busy", 16'(bus.busy), 16'(0));
    check("async_rst_done", 16'(bus.done), 16'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 16'(bus.busy), 16'(0));
    do_load(8'h01);
    start_op(3'b011, 4'd1, 8'h80, 1'b1);
    wait_done("post_rst_ror", 16'h0000, 1'b0);
    @(negedge clk);
    check("post_rst_done_clear", 16'(bus.done), 16'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
